exp_request_gen: RTL

Exception-request generator: the initiating side of the coprocessor-0 exception handshake. Synchronises three asynchronous external event lines and an internal periodic timer into pending bits, arbitrates them, and presents one request at a time on the `exp_src` lines. It holds each request until the exception is acknowledged, then stays in service until the handler executes `eret`.

---
 rtl/exp_request_gen_if.sv | 21 ++
 rtl/exp_request_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/exp_request_gen_if.sv
// Handshake bundle between the exception-request generator and CP0.
// master: the generator side; slave: the CP0 side that acknowledges and retires.
interface exp_request_gen_if;
  logic [2:0] exp_src;
  logic [2:0] pending;
  logic       busy;
  logic       ack_timeout;
  logic       exp_ack;
  logic       is_eret;
  logic       exp_block;

  modport master (
    output exp_src, pending, busy, ack_timeout,
    input  exp_ack, is_eret, exp_block
  );

  modport slave (
    input  exp_src, pending, busy, ack_timeout,
    output exp_ack, is_eret, exp_block
  );
endinterface

// File: rtl/exp_request_gen.sv
// Exception-request generator: synchronises external events and a periodic timer
// into pending bits and issues one prioritised request at a time to CP0.
module exp_request_gen #(
  parameter int unsigned TIMER_PERIOD = 1000,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        irq_in,
  input  logic              timer_en,
  exp_request_gen_if.master bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  localparam logic [15:0] PERIOD_M1  = 16'(TIMER_PERIOD - 1);
  localparam logic        TIMER_ON   = (TIMER_PERIOD != 0);
  localparam logic [7:0]  TIMEOUT_M1 = 8'(ACK_TIMEOUT - 1);

  logic [1:0]  state, state_nx;
  logic [2:0]  s1, s2, s3;
  logic [2:0]  rise;
  logic [2:0]  grant;
  logic [2:0]  clr;
  logic [2:0]  src_nx;
  logic [2:0]  pend_nx;
  logic [15:0] tcnt;
  logic        tick;
  logic [7:0]  to_cnt, to_cnt_nx;
  logic        to_pulse_nx;

  // Input synchroniser plus one extra stage for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = timer_en && TIMER_ON && (tcnt == PERIOD_M1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (timer_en && TIMER_ON) begin
      tcnt <= tick ? '0 : tcnt + 16'd1;
    end
  end

  assign rise = (s2 & ~s3) | {tick, 2'b00};

  always_comb begin
    grant = '0;
    if (bus.pending[0])      grant = 3'b001;
    else if (bus.pending[1]) grant = 3'b010;
    else if (bus.pending[2]) grant = 3'b100;
  end

  always_comb begin
    state_nx    = state;
    src_nx      = bus.exp_src;
    clr         = '0;
    to_cnt_nx   = to_cnt;
    to_pulse_nx = 1'b0;
    case (state)
      IDLE: begin
        if ((bus.pending != 3'b000) && !bus.exp_block) begin
          src_nx    = grant;
          to_cnt_nx = '0;
          state_nx  = REQ;
        end
      end
      REQ: begin
        // Acknowledge beats mask, mask beats timeout
        if (bus.exp_ack) begin
          src_nx   = '0;
          clr      = bus.exp_src;
          state_nx = SERVICE;
        end else if (bus.exp_block) begin
          src_nx   = '0;
          state_nx = IDLE;
        end else if (to_cnt == TIMEOUT_M1) begin
          src_nx      = '0;
          to_pulse_nx = 1'b1;
          state_nx    = IDLE;
        end else begin
          to_cnt_nx = to_cnt + 8'd1;
        end
      end
      SERVICE: begin
        if (bus.is_eret) state_nx = IDLE;
      end
      default: begin
        src_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Set wins over clear so an event coinciding with its own acknowledge survives
  assign pend_nx = (bus.pending & ~clr) | rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.exp_src     <= '0;
      bus.pending     <= '0;
      bus.ack_timeout <= 1'b0;
      to_cnt          <= '0;
    end else begin
      state           <= state_nx;
      bus.exp_src     <= src_nx;
      bus.pending     <= pend_nx;
      bus.ack_timeout <= to_pulse_nx;
      to_cnt          <= to_cnt_nx;
    end
  end

  assign bus.busy = (state != IDLE);

endmodule
